// File: rtl/mouse_tracker.sv
// ============================================================================
//  Module      : mouse_tracker
//  Description : Assembles 3-byte PS/2 mouse packets into an absolute, clamped
//                cursor position and button state. Optional crosshair hit
//                test enabled with MOUSE_TRACKER_CURSOR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_tracker #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CURSOR_R       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [9:0] MOUSE_X,
    output logic [9:0] MOUSE_Y,
    output logic       MOUSE_LEFT,
    output logic       MOUSE_RIGHT,
    output logic       MOUSE_MIDDLE,
    output logic       pkt_valid,
    output logic       left_press,
    output logic       sync_err
`ifdef MOUSE_TRACKER_CURSOR_EN
    ,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       cursor_valid
`endif
);

    localparam int              CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]      c_x_max   = 10'(SCREEN_W - 1);
    localparam logic [9:0]      c_y_max   = 10'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Header bits kept: {Yovf, Xovf, Ysign, Xsign, M, R, L}
    logic [6:0]       hdr_q, hdr_d;
    logic [7:0]       dxlo_q, dxlo_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             left_q, left_d, right_q, right_d, middle_q, middle_d;
    logic             pkt_q, pkt_d, press_q, press_d, err_q, err_d;

    logic signed [11:0] dx_s, dy_s, nx_s, ny_s;

    function automatic logic [9:0] clamp(input logic signed [11:0] v, input logic [9:0] lim);
        logic [9:0] r;
        if (v < 12'sd0)
            r = 10'd0;
        else if (v > $signed({2'b00, lim}))
            r = lim;
        else
            r = v[9:0];
        return r;
    endfunction

    always_comb begin
        dx_s = hdr_q[5] ? 12'sd0 : $signed({{3{hdr_q[3]}}, hdr_q[3], dxlo_q});
        dy_s = hdr_q[6] ? 12'sd0 : $signed({{3{hdr_q[4]}}, hdr_q[4], rx_data});
        nx_s = $signed({2'b00, x_q}) + dx_s;
        // PS/2 +Y points up while screen rows grow downward
        ny_s = $signed({2'b00, y_q}) - dy_s;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        dxlo_d   = dxlo_q;
        x_d      = x_q;
        y_d      = y_q;
        left_d   = left_q;
        right_d  = right_q;
        middle_d = middle_q;
        pkt_d    = 1'b0;
        press_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_B0: begin
                cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data[3]) begin
                        hdr_d   = {rx_data[7:4], rx_data[2:0]};
                        state_d = S_B1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_B1, S_B2: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (state_q == S_B1) begin
                        dxlo_d  = rx_data;
                        state_d = S_B2;
                    end else begin
                        x_d      = clamp(nx_s, c_x_max);
                        y_d      = clamp(ny_s, c_y_max);
                        left_d   = hdr_q[0];
                        right_d  = hdr_q[1];
                        middle_d = hdr_q[2];
                        pkt_d    = 1'b1;
                        press_d  = hdr_q[0] & ~left_q;
                        state_d  = S_B0;
                    end
                end else if (cnt_q == c_cnt_max) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_B0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_B0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_B0;
            cnt_q    <= '0;
            hdr_q    <= '0;
            dxlo_q   <= '0;
            x_q      <= 10'(INIT_X);
            y_q      <= 10'(INIT_Y);
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            middle_q <= 1'b0;
            pkt_q    <= 1'b0;
            press_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            dxlo_q   <= dxlo_d;
            x_q      <= x_d;
            y_q      <= y_d;
            left_q   <= left_d;
            right_q  <= right_d;
            middle_q <= middle_d;
            pkt_q    <= pkt_d;
            press_q  <= press_d;
            err_q    <= err_d;
        end
    end

    assign MOUSE_X      = x_q;
    assign MOUSE_Y      = y_q;
    assign MOUSE_LEFT   = left_q;
    assign MOUSE_RIGHT  = right_q;
    assign MOUSE_MIDDLE = middle_q;
    assign pkt_valid    = pkt_q;
    assign left_press   = press_q;
    assign sync_err     = err_q;

`ifdef MOUSE_TRACKER_CURSOR_EN
    localparam logic signed [10:0] c_r = 11'(CURSOR_R);
    logic signed [10:0] dh_s, dv_s;

    always_comb begin
        dh_s = $signed({1'b0, h_cnt}) - $signed({1'b0, x_q});
        dv_s = $signed({1'b0, v_cnt}) - $signed({1'b0, y_q});
        cursor_valid = ((h_cnt == x_q) && (dv_s <= c_r) && (dv_s >= -c_r)) ||
                       ((v_cnt == y_q) && (dh_s <= c_r) && (dh_s >= -c_r));
    end
`endif

endmodule

`default_nettype wire
